// File: rtl/my_node_info_pkg.sv
// Shared constants and types for the EER-RL node-info block.
// Packet-type codes, word width, the fixed-point unit and the heartbeat-lock state type.
package node_pkg;

  localparam int WORD_WIDTH = 16;

  localparam logic [2:0] PKT_HB   = 3'b000;
  localparam logic [2:0] PKT_CHE  = 3'b001;
  localparam logic [2:0] PKT_INV  = 3'b010;
  localparam logic [2:0] PKT_CHT  = 3'b100;
  localparam logic [2:0] PKT_DATA = 3'b101;

  // 1.0 in unsigned 2.14 fixed point.
  localparam logic [WORD_WIDTH-1:0] Q_ONE = 16'h4000;

  typedef enum logic {
    LOCK_OPEN = 1'b0,
    LOCK_HELD = 1'b1
  } hb_lock_e;

endpackage

// File: rtl/my_node_info_if.sv
// Field bus from the packet parser into the node-info block, plus the node state it publishes.
// Handshake: a packet is taken on every rising clk edge where en_MNI is high; there is no ready/back-pressure.
interface my_node_info_if;
  import node_pkg::*;

  logic                  en_MNI;
  logic [2:0]            fPktType;
  logic [WORD_WIDTH-1:0] energy;
  logic [WORD_WIDTH-1:0] destinationID;
  logic [WORD_WIDTH-1:0] hops;
  logic [WORD_WIDTH-1:0] timeslot;
  logic [WORD_WIDTH-1:0] e_threshold;

  logic [WORD_WIDTH-1:0] myNodeID;
  logic [WORD_WIDTH-1:0] hopsFromSink;
  logic [WORD_WIDTH-1:0] myQValue;
  logic                  role;
  logic                  low_E;

  // Observability of internal state for checkers.
  hb_lock_e              dbg_lock;
  logic [WORD_WIDTH-1:0] dbg_timeslot;

  modport master (
    output en_MNI, fPktType, energy, destinationID, hops, timeslot, e_threshold,
    input  myNodeID, hopsFromSink, myQValue, role, low_E, dbg_lock, dbg_timeslot
  );

  modport slave (
    input  en_MNI, fPktType, energy, destinationID, hops, timeslot, e_threshold,
    output myNodeID, hopsFromSink, myQValue, role, low_E, dbg_lock, dbg_timeslot
  );

endinterface

// File: rtl/my_node_info_q_init_div.sv
// Initial Q-value: residual energy (2.14) divided by integer hop count, truncated.
// A zero hop count means the node is adjacent to the sink, so the energy passes straight through.
module q_init_div
  import node_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] i_dividend,
  input  logic [WORD_WIDTH-1:0] i_divisor,
  output logic [WORD_WIDTH-1:0] o_quotient
);

  always_comb begin
    o_quotient = i_dividend;
    if (i_divisor != '0) begin
      o_quotient = i_dividend / i_divisor;
    end
  end

endmodule

// File: rtl/my_node_info.sv
// Per-node state register for the EER-RL cluster-routing node.
// Decodes parsed packets from the field bus and keeps hop distance, initial Q-value, role and low-energy flag.
module my_node_info
  import node_pkg::*;
#(
  parameter logic [WORD_WIDTH-1:0] NODE_ID = 16'h000C
) (
  input  logic           clk,
  input  logic           nrst,
  my_node_info_if.slave  bus
);

  hb_lock_e              r_lock_state;
  hb_lock_e              w_lock_next;
  logic [WORD_WIDTH-1:0] r_hops_from_sink;
  logic [WORD_WIDTH-1:0] r_q_value;
  logic                  r_role;
  logic                  r_low_e;
  logic [WORD_WIDTH-1:0] r_timeslot;
  logic [WORD_WIDTH-1:0] w_q_init;
  logic                  w_hb_accept;
  logic                  w_for_me;

  q_init_div u_q_init_div (
    .i_dividend (bus.energy),
    .i_divisor  (bus.hops),
    .o_quotient (w_q_init)
  );

  assign w_for_me    = (bus.destinationID == NODE_ID);
  assign w_hb_accept = bus.en_MNI && (bus.fPktType == PKT_HB) && (r_lock_state == LOCK_OPEN);

  // Heartbeat lock: one HB per round; CHT or DATA traffic marks the round over.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_lock_state <= LOCK_OPEN;
    end else begin
      r_lock_state <= w_lock_next;
    end
  end

  always_comb begin
    w_lock_next = r_lock_state;
    if (bus.en_MNI) begin
      case (bus.fPktType)
        PKT_HB:   w_lock_next = LOCK_HELD;
        PKT_CHT,
        PKT_DATA: w_lock_next = LOCK_OPEN;
        default:  w_lock_next = r_lock_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_hops_from_sink <= '1;
      r_q_value        <= '0;
      r_role           <= 1'b0;
      r_low_e          <= 1'b0;
      r_timeslot       <= '1;
    end else if (bus.en_MNI) begin
      if (w_hb_accept) begin
        r_hops_from_sink <= bus.hops;
        r_q_value        <= w_q_init;
        r_low_e          <= (bus.energy < bus.e_threshold);
        r_role           <= 1'b0;
      end
      if (bus.fPktType == PKT_CHE) begin
        r_role <= w_for_me;
      end
      // A cluster head owns the schedule, so only members accept a slot assignment.
      if ((bus.fPktType == PKT_CHT) && !r_role && w_for_me) begin
        r_timeslot <= bus.timeslot;
      end
    end
  end

  assign bus.myNodeID     = NODE_ID;
  assign bus.hopsFromSink = r_hops_from_sink;
  assign bus.myQValue     = r_q_value;
  assign bus.role         = r_role;
  assign bus.low_E        = r_low_e;
  assign bus.dbg_lock     = r_lock_state;
  assign bus.dbg_timeslot = r_timeslot;

endmodule

// File: tb/tb_my_node_info.sv
// Directed bench for my_node_info: linear packet sequence with hand-computed expectations.
module tb_my_node_info;
  import node_pkg::*;

  logic clk;
  logic nrst;
  int   n_checks;
  int   n_fail;

  my_node_info_if bus ();

  my_node_info #(.NODE_ID(16'h000C)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [15:0] e_hops, input logic [15:0] e_q,
                             input logic e_role, input logic e_low, input logic e_lock);
    check({tag, ".hopsFromSink"}, bus.hopsFromSink, e_hops);
    check({tag, ".myQValue"}, bus.myQValue, e_q);
    check({tag, ".role"}, {15'd0, bus.role}, {15'd0, e_role});
    check({tag, ".low_E"}, {15'd0, bus.low_E}, {15'd0, e_low});
    check({tag, ".lock"}, {15'd0, bus.dbg_lock}, {15'd0, e_lock});
  endtask

  // Driver: present one packet for n_cycles rising edges, then sample 1 time unit after the last edge.
  task automatic send(input logic [2:0] t, input logic [15:0] dest, input logic [15:0] h,
                      input logic [15:0] e, input logic [15:0] ts, input int n_cycles);
    @(negedge clk);
    bus.fPktType      = t;
    bus.destinationID = dest;
    bus.hops          = h;
    bus.energy        = e;
    bus.timeslot      = ts;
    bus.en_MNI        = 1'b1;
    repeat (n_cycles) @(posedge clk);
    #1;
    bus.en_MNI = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.en_MNI        = 1'b0;
    bus.fPktType      = PKT_INV;
    bus.energy        = 16'h0000;
    bus.destinationID = 16'h0000;
    bus.hops          = 16'h0000;
    bus.timeslot      = 16'h0000;
    bus.e_threshold   = 16'h3333;
    nrst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst.myNodeID", bus.myNodeID, 16'h000C);
    check_state("rst", 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("rst.timeslot", bus.dbg_timeslot, 16'hFFFF);
    @(negedge clk);
    nrst = 1'b1;

    send(PKT_HB, 16'h0000, 16'd1, 16'h8000, 16'h0000, 1);
    check_state("hb1", 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1);

    send(PKT_HB, 16'h0000, 16'd2, 16'h7FC0, 16'h0000, 1);
    check_state("hb_locked", 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1);

    send(PKT_CHE, 16'h0020, 16'd0, 16'h0000, 16'h0000, 1);
    check("che_other.role", {15'd0, bus.role}, 16'h0000);
    send(PKT_INV, 16'h0020, 16'd0, 16'h0000, 16'h0000, 1);
    check("inv.role", {15'd0, bus.role}, 16'h0000);
    send(PKT_CHE, 16'h000C, 16'd0, 16'h0000, 16'h0000, 1);
    check("che_me.role", {15'd0, bus.role}, 16'h0001);

    send(PKT_CHT, 16'h0015, 16'd0, 16'h0000, 16'd4, 1);
    check_state("cht_other", 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b0);
    check("cht_other.timeslot", bus.dbg_timeslot, 16'hFFFF);

    // Cluster head ignores a slot addressed to itself.
    send(PKT_CHT, 16'h000C, 16'd0, 16'h0000, 16'd9, 1);
    check("cht_ch.timeslot", bus.dbg_timeslot, 16'hFFFF);

    send(PKT_DATA, 16'h000E, 16'd3, 16'h0000, 16'h0000, 1);
    check_state("data1", 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b0);

    send(PKT_HB, 16'h0000, 16'd1, 16'h6000, 16'h0000, 1);
    check_state("hb2", 16'h0001, 16'h6000, 1'b0, 1'b0, 1'b1);
    send(PKT_HB, 16'h0000, 16'd2, 16'h2000, 16'h0000, 1);
    check_state("hb2_locked", 16'h0001, 16'h6000, 1'b0, 1'b0, 1'b1);

    send(PKT_CHT, 16'h000C, 16'd0, 16'h0000, 16'd7, 1);
    check("cht_member.timeslot", bus.dbg_timeslot, 16'h0007);
    check("cht_member.lock", {15'd0, bus.dbg_lock}, 16'h0000);

    send(PKT_HB, 16'h0000, 16'd4, 16'h3000, 16'h0000, 1);
    check_state("hb_div4", 16'h0004, 16'h0C00, 1'b0, 1'b1, 1'b1);

    // en_MNI low and reserved packet types leave everything alone.
    @(negedge clk);
    bus.fPktType = PKT_DATA;
    bus.hops     = 16'd9;
    repeat (2) @(posedge clk);
    #1;
    check_state("idle", 16'h0004, 16'h0C00, 1'b0, 1'b1, 1'b1);
    send(3'b011, 16'h000C, 16'd5, 16'h1000, 16'd3, 1);
    send(3'b110, 16'h000C, 16'd5, 16'h1000, 16'd3, 1);
    send(3'b111, 16'h000C, 16'd5, 16'h1000, 16'd3, 1);
    check_state("reserved", 16'h0004, 16'h0C00, 1'b0, 1'b1, 1'b1);
    check("reserved.timeslot", bus.dbg_timeslot, 16'h0007);

    send(PKT_DATA, 16'h0001, 16'd0, 16'h0000, 16'h0000, 1);
    send(PKT_HB, 16'h0000, 16'd0, 16'h1234, 16'h0000, 1);
    check_state("hb_hops0", 16'h0000, 16'h1234, 1'b0, 1'b1, 1'b1);

    // HB held for 3 edges: the first is taken, the repeats hit the lock.
    send(PKT_DATA, 16'h0001, 16'd0, 16'h0000, 16'h0000, 1);
    send(PKT_HB, 16'h0000, 16'd3, 16'h4000, 16'h0000, 3);
    check_state("hb_held", 16'h0003, 16'h1555, 1'b0, 1'b0, 1'b1);

    send(PKT_CHE, 16'h000C, 16'd0, 16'h0000, 16'h0000, 1);
    check("che_me2.role", {15'd0, bus.role}, 16'h0001);

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    check_state("async_rst", 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("async_rst.timeslot", bus.dbg_timeslot, 16'hFFFF);
    check("async_rst.myNodeID", bus.myNodeID, 16'h000C);
    @(negedge clk);
    nrst = 1'b1;

    send(PKT_HB, 16'h0000, 16'd2, 16'h2000, 16'h0000, 1);
    check_state("hb_after_rst", 16'h0002, 16'h1000, 1'b0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
